ppu_line_feeder: RTL and testbench

PPU_LINE_FEEDER -- requirements
Module: ppu_line_feeder

---
 rtl/ppu_line_feeder_if.sv | 25 ++
 rtl/ppu_line_feeder.sv | 95 +++++++++
 tb/tb_ppu_line_feeder.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ppu_line_feeder_if.sv
// ppu_line_feeder_if: bus between the PPU pixel source and the line feeder
// master: drives ppu_wr/ppu_index pushes, greyscale/emphasis/backdrop controls and clr_flags
// slave : returns red/green/blue_dout, fifo_level and the sticky overflow/underflow flags
interface ppu_line_feeder_if;
  logic       ppu_wr;
  logic [5:0] ppu_index;
  logic       greyscale;
  logic [2:0] emphasis;
  logic [5:0] backdrop;
  logic       clr_flags;
  logic [7:0] red_dout;
  logic [7:0] green_dout;
  logic [7:0] blue_dout;
  logic [9:0] fifo_level;
  logic       overflow;
  logic       underflow;
  modport master (
    output ppu_wr, ppu_index, greyscale, emphasis, backdrop, clr_flags,
    input  red_dout, green_dout, blue_dout, fifo_level, overflow, underflow
  );
  modport slave (
    input  ppu_wr, ppu_index, greyscale, emphasis, backdrop, clr_flags,
    output red_dout, green_dout, blue_dout, fifo_level, overflow, underflow
  );
endinterface

// File: rtl/ppu_line_feeder.sv
// ppu_line_feeder: buffers PPU palette indices and streams them as RGB in step with the VGA line cadence
// pclk/rst : pixel clock and synchronous active-high reset
// bus      : slave side of ppu_line_feeder_if (index pushes and controls in; RGB, level and flags out)
module ppu_line_feeder #(
  parameter int H_OFFSET    = 64,
  parameter int LINE_CYCLES = 1600,
  parameter int FIFO_DEPTH  = 512
) (
  input logic              pclk,
  input logic              rst,
  ppu_line_feeder_if.slave bus
);
  localparam int CW = $clog2(LINE_CYCLES);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST    = CW'(LINE_CYCLES - 1);
  localparam logic [CW-1:0] ACT0    = CW'(2 * H_OFFSET);
  localparam logic [CW-1:0] ACT_END = CW'(2 * H_OFFSET + 1024);
  // pixel p is popped 4 cycles before its first output cycle: read, modify, ROM and output registers
  localparam logic [CW-1:0] POP0    = CW'(2 * H_OFFSET - 4);
  localparam logic [CW-1:0] POP_END = CW'(2 * H_OFFSET + 1020);
  localparam logic [9:0]    FULL    = 10'(FIFO_DEPTH);
  localparam logic [23:0] PAL [64] = '{
    24'h666666, 24'h002A88, 24'h1412A7, 24'h3B00A4, 24'h5C007E, 24'h6E0040, 24'h6C0600, 24'h561D00,
    24'h333500, 24'h0B4800, 24'h005200, 24'h004F08, 24'h00404D, 24'h000000, 24'h000000, 24'h000000,
    24'hADADAD, 24'h155FD9, 24'h4240FF, 24'h7527FE, 24'hA01ACC, 24'hB71E7B, 24'hB53120, 24'h994E00,
    24'h6B6D00, 24'h388700, 24'h0C9300, 24'h008F32, 24'h007C8D, 24'h000000, 24'h000000, 24'h000000,
    24'hFFFEFF, 24'h64B0FF, 24'h9290FF, 24'hC676FF, 24'hF36AFF, 24'hFE6ECC, 24'hFE8170, 24'hEA9E22,
    24'hBCBE00, 24'h88D800, 24'h5CE430, 24'h45E082, 24'h48CDDE, 24'h4F4F4F, 24'h000000, 24'h000000,
    24'hFFFEFF, 24'hC0DFFF, 24'hD3D2FF, 24'hE8C8FF, 24'hFBC2FF, 24'hFEC4EA, 24'hFECCC5, 24'hF7D8A5,
    24'hE4E594, 24'hCFEF96, 24'hBDF4AB, 24'hB3F3CC, 24'hB5EBF2, 24'hB8B8B8, 24'h000000, 24'h000000
  };
  logic [CW-1:0] cnt, cnt_nxt;
  logic [5:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [9:0]    level;
  logic          pop, empty, full, push_ok, pop_ok, ov_ev, un_ev, act, d1;
  logic [5:0]    rd_idx, mod_idx;
  logic [2:0]    e1, e2, keep;
  logic [23:0]   pal_rgb, rgb_emph;
  function automatic logic [7:0] dim(input logic [7:0] v, input logic k);
    return k ? v : v - (v >> 2);
  endfunction
  always_comb begin
    cnt_nxt  = cnt == LAST ? '0 : cnt + 1'b1;
    pop      = cnt >= POP0 && cnt < POP_END && cnt[1:0] == POP0[1:0];
    empty    = level == '0;
    full     = level == FULL;
    pop_ok   = pop && !empty;
    un_ev    = pop && empty;
    // a pop frees a slot in the same cycle, so a push to a full FIFO is still accepted
    push_ok  = bus.ppu_wr && (!full || pop);
    ov_ev    = bus.ppu_wr && full && !pop;
    act      = cnt_nxt >= ACT0 && cnt_nxt < ACT_END;
    keep     = e2 == 3'b000 ? 3'b111 : e2;
    rgb_emph = {dim(pal_rgb[23:16], keep[0]), dim(pal_rgb[15:8], keep[1]), dim(pal_rgb[7:0], keep[2])};
  end
  always_ff @(posedge pclk) begin
    if (push_ok) mem[wptr] <= bus.ppu_index;
  end
  always_ff @(posedge pclk) begin
    if (rst) begin
      cnt           <= '0;
      wptr          <= '0;
      rptr          <= '0;
      level         <= '0;
      bus.overflow  <= 1'b0;
      bus.underflow <= 1'b0;
      rd_idx        <= '0;
      d1            <= 1'b0;
      mod_idx       <= '0;
      e1            <= '0;
      e2            <= '0;
      pal_rgb       <= '0;
      {bus.red_dout, bus.green_dout, bus.blue_dout} <= '0;
    end else begin
      cnt           <= cnt_nxt;
      wptr          <= push_ok ? wptr + 1'b1 : wptr;
      rptr          <= pop_ok ? rptr + 1'b1 : rptr;
      level         <= level + {9'd0, push_ok} - {9'd0, pop_ok};
      bus.overflow  <= ov_ev | (bus.overflow & ~bus.clr_flags);
      bus.underflow <= un_ev | (bus.underflow & ~bus.clr_flags);
      if (pop) rd_idx <= empty ? bus.backdrop : mem[rptr];
      d1            <= pop;
      // controls are captured once per popped pixel so later changes never touch it
      if (d1) begin
        mod_idx <= bus.greyscale ? rd_idx & 6'h30 : rd_idx;
        e1      <= bus.emphasis;
      end
      pal_rgb       <= PAL[mod_idx];
      e2            <= e1;
      {bus.red_dout, bus.green_dout, bus.blue_dout} <= act ? rgb_emph : '0;
    end
  end
  assign bus.fifo_level = level;
endmodule

// File: tb/tb_ppu_line_feeder.sv
// tb_ppu_line_feeder: randomized and directed checks of ppu_line_feeder against a queue-based line model
module tb_ppu_line_feeder;
  localparam int H    = 64;
  localparam int LC   = 1600;
  localparam int POP0 = 2 * H - 4;
  localparam logic [23:0] PAL [64] = '{
    24'h666666, 24'h002A88, 24'h1412A7, 24'h3B00A4, 24'h5C007E, 24'h6E0040, 24'h6C0600, 24'h561D00,
    24'h333500, 24'h0B4800, 24'h005200, 24'h004F08, 24'h00404D, 24'h000000, 24'h000000, 24'h000000,
    24'hADADAD, 24'h155FD9, 24'h4240FF, 24'h7527FE, 24'hA01ACC, 24'hB71E7B, 24'hB53120, 24'h994E00,
    24'h6B6D00, 24'h388700, 24'h0C9300, 24'h008F32, 24'h007C8D, 24'h000000, 24'h000000, 24'h000000,
    24'hFFFEFF, 24'h64B0FF, 24'h9290FF, 24'hC676FF, 24'hF36AFF, 24'hFE6ECC, 24'hFE8170, 24'hEA9E22,
    24'hBCBE00, 24'h88D800, 24'h5CE430, 24'h45E082, 24'h48CDDE, 24'h4F4F4F, 24'h000000, 24'h000000,
    24'hFFFEFF, 24'hC0DFFF, 24'hD3D2FF, 24'hE8C8FF, 24'hFBC2FF, 24'hFEC4EA, 24'hFECCC5, 24'hF7D8A5,
    24'hE4E594, 24'hCFEF96, 24'hBDF4AB, 24'hB3F3CC, 24'hB5EBF2, 24'hB8B8B8, 24'h000000, 24'h000000
  };
  logic pclk = 1'b0;
  logic rst  = 1'b1;
  ppu_line_feeder_if bus();
  ppu_line_feeder #(.H_OFFSET(H), .LINE_CYCLES(LC), .FIFO_DEPTH(512)) dut (.pclk(pclk), .rst(rst), .bus(bus));
  always #5 pclk = ~pclk;
  int errors = 0;
  int checks = 0;
  int tcnt = 0;
  bit m_ov = 0;
  bit m_un = 0;
  logic [5:0]  q [$];
  logic [23:0] pix [256];
  logic [35:0] got, want;
  function automatic logic [23:0] color(input logic [5:0] idx, input logic g, input logic [2:0] e);
    logic [23:0] v;
    logic [7:0] ch [3];
    v = PAL[g ? idx & 6'h30 : idx];
    ch[0] = v[23:16];
    ch[1] = v[15:8];
    ch[2] = v[7:0];
    for (int k = 0; k < 3; k++) if (e != 3'b000 && !e[k]) ch[k] = ch[k] - ch[k] / 8'd4;
    return {ch[0], ch[1], ch[2]};
  endfunction
  task automatic tick();
    int sz;
    bit popping;
    logic [5:0] idx;
    @(posedge pclk);
    if (rst) begin
      q.delete();
      m_ov = 0;
      m_un = 0;
      tcnt = 0;
    end else begin
      sz = q.size();
      popping = tcnt >= POP0 && tcnt < POP0 + 1024 && (tcnt - POP0) % 4 == 0;
      m_ov = m_ov && !bus.clr_flags;
      m_un = m_un && !bus.clr_flags;
      if (popping) begin
        if (sz > 0) idx = q.pop_front();
        else begin
          idx = bus.backdrop;
          m_un = 1;
        end
        pix[(tcnt - POP0) / 4] = color(idx, bus.greyscale, bus.emphasis);
      end
      if (bus.ppu_wr) begin
        if (sz < 512 || popping) q.push_back(bus.ppu_index);
        else m_ov = 1;
      end
      tcnt = (tcnt + 1) % LC;
    end
    #1;
    want = {(tcnt / 2 >= H && tcnt / 2 < H + 512) ? pix[(tcnt / 2 - H) / 2] : 24'h0, 10'(q.size()), m_ov, m_un};
    got  = {bus.red_dout, bus.green_dout, bus.blue_dout, bus.fifo_level, bus.overflow, bus.underflow};
  endtask
  task automatic test_reset();
    rst = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (got !== 36'h0) begin errors++; $display("FAIL reset got=%h want=0", got); end
    end
    rst = 0;
  endtask
  task automatic test_solid();
    for (int i = 0; i < LC; i++) begin
      bus.ppu_wr = i < 256;
      bus.ppu_index = 6'h16;
      tick();
      checks++;
      if (got !== want) begin errors++; $display("FAIL solid t=%0d got=%h want=%h", tcnt, got, want); end
      if (tcnt == 2 * H || tcnt == 2 * H + 1023) begin
        checks++;
        if (got[35:12] !== 24'hB53120) begin errors++; $display("FAIL solid_edge t=%0d rgb=%h want=B53120", tcnt, got[35:12]); end
      end
      if (tcnt == 2 * H - 1 || tcnt == 2 * H + 1024) begin
        checks++;
        if (got[35:12] !== 24'h0) begin errors++; $display("FAIL solid_blank t=%0d rgb=%h want=000000", tcnt, got[35:12]); end
      end
    end
    bus.ppu_wr = 0;
    checks++;
    if (got[11:0] !== 12'h0) begin errors++; $display("FAIL solid_end level/flags=%h want=000", got[11:0]); end
  endtask
  task automatic test_greyscale_emphasis();
    for (int m = 0; m < 2; m++) begin
      bus.greyscale = m == 0;
      bus.emphasis = m == 1 ? 3'b001 : 3'b000;
      for (int i = 0; i < LC; i++) begin
        bus.ppu_wr = i < 256;
        bus.ppu_index = 6'h16;
        tick();
        checks++;
        if (got !== want) begin errors++; $display("FAIL grey_emph m=%0d t=%0d got=%h want=%h", m, tcnt, got, want); end
        if (tcnt == 2 * H + 200) begin
          checks++;
          if (got[35:12] !== (m == 0 ? 24'hADADAD : 24'hB52518))
            begin errors++; $display("FAIL grey_emph_spot m=%0d rgb=%h", m, got[35:12]); end
        end
      end
    end
    bus.ppu_wr = 0;
    bus.greyscale = 0;
    bus.emphasis = 0;
  endtask
  task automatic test_underflow();
    bit chk;
    logic eu;
    bus.backdrop = 6'h0F;
    for (int l = 0; l < 2; l++) begin
      for (int i = 0; i < LC; i++) begin
        bus.clr_flags = l == 1 && (tcnt == 0 || tcnt == POP0 || tcnt == POP0 + 1);
        tick();
        checks++;
        if (got !== want) begin errors++; $display("FAIL underflow l=%0d t=%0d got=%h want=%h", l, tcnt, got, want); end
        chk = 1;
        eu = 0;
        if (l == 0 && tcnt == POP0) eu = 0;
        else if (l == 0 && tcnt == POP0 + 1) eu = 1;
        else if (l == 1 && tcnt == 1) eu = 0;
        else if (l == 1 && tcnt == POP0 + 1) eu = 1;
        else if (l == 1 && tcnt == POP0 + 2) eu = 0;
        else chk = 0;
        if (chk) begin
          checks++;
          if (got[0] !== eu) begin errors++; $display("FAIL underflow_flag l=%0d t=%0d got=%b want=%b", l, tcnt, got[0], eu); end
        end
        if (tcnt == 2 * H + 100) begin
          checks++;
          if (got[35:12] !== 24'h0) begin errors++; $display("FAIL underflow_rgb rgb=%h want=000000", got[35:12]); end
        end
      end
    end
    bus.clr_flags = 0;
  endtask
  task automatic test_overflow();
    bit saw = 0;
    while (tcnt != POP0 + 1024) begin
      tick();
      checks++;
      if (got !== want) begin errors++; $display("FAIL overflow_idle t=%0d got=%h want=%h", tcnt, got, want); end
    end
    for (int i = 0; i < 513; i++) begin
      bus.ppu_wr = 1;
      bus.ppu_index = i == 512 ? 6'h30 : 6'($urandom_range(0, 31));
      tick();
      checks++;
      if (got !== want) begin errors++; $display("FAIL overflow_fill t=%0d got=%h want=%h", tcnt, got, want); end
    end
    bus.ppu_wr = 0;
    checks++;
    if (got[11:1] !== {10'd512, 1'b1}) begin errors++; $display("FAIL overflow_full level=%0d ov=%b want 512/1", got[11:2], got[1]); end
    for (int i = 0; i < 2 * LC; i++) begin
      tick();
      checks++;
      if (got !== want) begin errors++; $display("FAIL overflow_drain t=%0d got=%h want=%h", tcnt, got, want); end
      if (got[35:12] === 24'hFFFEFF) saw = 1;
    end
    checks++;
    if (saw || got[11:2] !== 10'd0) begin errors++; $display("FAIL overflow_drop saw513=%b level=%0d want 0/0", saw, got[11:2]); end
    bus.clr_flags = 1;
    tick();
    bus.clr_flags = 0;
    checks++;
    if (got[1:0] !== 2'b00) begin errors++; $display("FAIL overflow_clr flags=%b want=00", got[1:0]); end
  endtask
  task automatic test_reset_mid();
    bit lit = 0;
    while (tcnt != 0) begin
      tick();
      checks++;
      if (got !== want) begin errors++; $display("FAIL rstmid_idle t=%0d got=%h want=%h", tcnt, got, want); end
    end
    for (int i = 0; i < 900; i++) begin
      bus.ppu_wr = i < 294;
      bus.ppu_index = 6'($urandom_range(0, 63));
      tick();
      checks++;
      if (got !== want) begin errors++; $display("FAIL rstmid_fill t=%0d got=%h want=%h", tcnt, got, want); end
    end
    bus.ppu_wr = 0;
    checks++;
    if (got[11:2] !== 10'd100) begin errors++; $display("FAIL rstmid_level level=%0d want=100", got[11:2]); end
    rst = 1;
    tick();
    rst = 0;
    checks++;
    if (got !== 36'h0) begin errors++; $display("FAIL rstmid_after got=%h want=0", got); end
    bus.backdrop = 6'h0F;
    for (int i = 0; i < LC; i++) begin
      tick();
      checks++;
      if (got !== want) begin errors++; $display("FAIL rstmid_line t=%0d got=%h want=%h", tcnt, got, want); end
      if (got[35:12] !== 24'h0) lit = 1;
    end
    checks++;
    if (lit) begin errors++; $display("FAIL rstmid_black lit=%b want=0", lit); end
  endtask
  task automatic test_emphasis_change();
    for (int i = 0; i < LC; i++) begin
      bus.ppu_wr = i < 256;
      bus.ppu_index = 6'h30;
      if (tcnt == 600) bus.emphasis = 3'b010;
      tick();
      checks++;
      if (got !== want) begin errors++; $display("FAIL emph_change t=%0d got=%h want=%h", tcnt, got, want); end
      if (tcnt == 2 * H || tcnt == 603 || tcnt == 604) begin
        checks++;
        if (got[35:12] !== (tcnt == 604 ? 24'hC0FEC0 : 24'hFFFEFF))
          begin errors++; $display("FAIL emph_change_spot t=%0d rgb=%h", tcnt, got[35:12]); end
      end
    end
    bus.ppu_wr = 0;
    bus.emphasis = 0;
  endtask
  task automatic test_random();
    for (int l = 0; l < 6; l++) begin
      for (int i = 0; i < LC; i++) begin
        bus.ppu_wr = $urandom_range(0, 99) < 10 + 8 * l;
        bus.ppu_index = 6'($urandom_range(0, 63));
        bus.backdrop = 6'($urandom_range(0, 63));
        bus.clr_flags = $urandom_range(0, 49) == 0;
        if (tcnt % 4 == 0 && $urandom_range(0, 15) == 0) begin
          bus.greyscale = 1'($urandom_range(0, 1));
          bus.emphasis = 3'($urandom_range(0, 7));
        end
        tick();
        checks++;
        if (got !== want) begin errors++; $display("FAIL random l=%0d t=%0d got=%h want=%h", l, tcnt, got, want); end
      end
    end
  endtask
  initial begin
    bus.ppu_wr = 0;
    bus.ppu_index = 0;
    bus.greyscale = 0;
    bus.emphasis = 0;
    bus.backdrop = 0;
    bus.clr_flags = 0;
    test_reset();
    test_solid();
    test_greyscale_emphasis();
    test_underflow();
    test_overflow();
    test_reset_mid();
    test_emphasis_change();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
